// File: rtl/vga_frame_streamer.sv
// VGA timing generator that pops one RGB565 word per active pixel from the SDRAM read FIFO.
// Streaming arms only at a frame origin so FIFO word 0 lands on pixel (0,0).
module vga_frame_streamer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        frame_start,
  output logic        streaming,
  output logic [15:0] underflow_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  typedef enum logic {ST_ARM = 1'b0, ST_STREAM = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic          pop_q, pop_d, fs_q, fs_d, streaming_q, streaming_d;
  logic [15:0]   underflow_cnt_q, underflow_cnt_d;
  logic          active0, hs0, vs0, origin0, underflow0;

  // Stage 0: free-running raster counters and the decoded regions.
  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (int'(h_cnt_q) == H_TOTAL - 1) begin
      h_cnt_d = '0;
      v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
    end
  end

  assign active0 = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
  assign hs0     = !((int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                     (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC));
  assign vs0     = !((int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                     (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC));
  assign origin0 = (h_cnt_q == '0) && (v_cnt_q == '0);

  // The arming cycle already pops pixel (0,0); rst_n gating keeps the strobe quiet in reset.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    underflow0 = 1'b0;
    case (state_q)
      ST_ARM: begin
        if (origin0 && !fifo_empty) begin
          state_d    = ST_STREAM;
          fifo_rd_en = rst_n;
        end
      end
      ST_STREAM: begin
        fifo_rd_en = rst_n && active0 && !fifo_empty;
        underflow0 = active0 && fifo_empty;
      end
      default: state_d = ST_ARM;
    endcase
  end

  // Stage 1: everything delayed one cycle to line up with fifo_dout.
  always_comb begin
    hs_d            = hs0;
    vs_d            = vs0;
    de_d            = active0;
    pop_d           = fifo_rd_en;
    fs_d            = origin0;
    streaming_d     = (state_d == ST_STREAM);
    underflow_cnt_d = underflow_cnt_q;
    if (underflow0 && (underflow_cnt_q != 16'hFFFF)) underflow_cnt_d = underflow_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_ARM;
      h_cnt_q         <= '0;
      v_cnt_q         <= '0;
      hs_q            <= 1'b1;
      vs_q            <= 1'b1;
      de_q            <= 1'b0;
      pop_q           <= 1'b0;
      fs_q            <= 1'b0;
      streaming_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      h_cnt_q         <= h_cnt_d;
      v_cnt_q         <= v_cnt_d;
      hs_q            <= hs_d;
      vs_q            <= vs_d;
      de_q            <= de_d;
      pop_q           <= pop_d;
      fs_q            <= fs_d;
      streaming_q     <= streaming_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  // FIFO data arrives during the display cycle, so colour is gated rather than registered.
  assign vga_r         = pop_q ? fifo_dout[15:11] : 5'd0;
  assign vga_g         = pop_q ? fifo_dout[10:5]  : 6'd0;
  assign vga_b         = pop_q ? fifo_dout[4:0]   : 5'd0;
  assign vga_hsync     = hs_q;
  assign vga_vsync     = vs_q;
  assign vga_de        = de_q;
  assign frame_start   = fs_q;
  assign streaming     = streaming_q;
  assign underflow_cnt = underflow_cnt_q;
endmodule

// File: tb/tb_vga_frame_streamer.sv
// Bench for vga_frame_streamer on a shrunken 16x8 raster (8x4 visible) with a counting FIFO model.
module tb_vga_frame_streamer;
  localparam int H_TOT = 16;
  localparam int V_TOT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [15:0] fifo_dout = 16'h0000;
  logic        fifo_rd_en, vga_hsync, vga_vsync, vga_de, frame_start, streaming;
  logic [4:0]  vga_r, vga_b;
  logic [5:0]  vga_g;
  logic [15:0] underflow_cnt;

  vga_frame_streamer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_de(vga_de), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .streaming(streaming), .underflow_cnt(underflow_cnt)
  );

  // Clock and FIFO model: each pop returns the next word of 0xF800, 0xF801, ...
  always #5 clk = ~clk;

  int fifo_ptr = 0;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= 16'hF800 + 16'(fifo_ptr);
      fifo_ptr  <= fifo_ptr + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_push = 0;
  int n_de, n_hs, n_vs, n_pop, n_blank_pop, n_strm, n_black;
  logic prev_rd = 1'b0;
  logic [15:0] exp_q[$];

  typedef struct {
    int   k;
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_de = 0; n_hs = 0; n_vs = 0; n_pop = 0; n_blank_pop = 0; n_strm = 0; n_black = 0;
  endtask

  // One clock: drive fifo_empty after the edge, then sample and score the outputs.
  task automatic step(input logic e);
    logic [15:0] pix;
    int h, v;
    @(posedge clk);
    #2;
    cyc++;
    fifo_empty = e;
    #1;
    h   = cyc % H_TOT;
    v   = (cyc / H_TOT) % V_TOT;
    pix = {vga_r, vga_g, vga_b};
    if (vga_de) n_de++;
    if (!vga_hsync) n_hs++;
    if (!vga_vsync) n_vs++;
    if (streaming) n_strm++;
    if (vga_de && pix == 16'h0) n_black++;
    if (prev_rd) begin
      if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
      else check("pixel", {16'h0, pix}, {16'h0, exp_q.pop_front()});
    end else begin
      check("black", {16'h0, pix}, 32'h0);
    end
    if (fifo_rd_en) begin
      n_pop++;
      if (!(h < 8 && v < 4)) n_blank_pop++;
      exp_q.push_back(16'hF800 + 16'(n_push));
      n_push++;
    end
    prev_rd = fifo_rd_en;
  endtask

  task automatic run_to(input int target, input logic e);
    while (cyc < target) step(e);
  endtask

  initial begin
    // Sample k shows the stage-1 image of raster position k-1.
    vecs[0]  = '{0,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1,   1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{2,   1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{8,   1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{9,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{10,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{11,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{13,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{14,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{17,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{65,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{81,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{97,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{113, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{124, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{129, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n      = 1'b0;
    fifo_empty = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #3;
    check("rst_hsync", 32'(vga_hsync), 32'd1);
    check("rst_vsync", 32'(vga_vsync), 32'd1);
    check("rst_de", 32'(vga_de), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_streaming", 32'(streaming), 32'd0);
    check("rst_ufcnt", 32'(underflow_cnt), 32'd0);
    @(posedge clk);
    #2;
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    cyc = 0;
    #1;

    // Timing with FIFO always empty: table points, then two-frame totals.
    for (int i = 0; i < 16; i++) begin
      run_to(vecs[i].k, 1'b1);
      check("tbl_hsync", 32'(vga_hsync), 32'(vecs[i].hs));
      check("tbl_vsync", 32'(vga_vsync), 32'(vecs[i].vs));
      check("tbl_de", 32'(vga_de), 32'(vecs[i].de));
      check("tbl_fs", 32'(frame_start), 32'(vecs[i].fs));
      check("tbl_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    run_to(256, 1'b1);
    check("two_frame_de", n_de, 64);
    check("two_frame_hs_low", n_hs, 48);
    check("two_frame_vs_low", n_vs, 64);
    check("two_frame_pops", n_pop, 0);
    check("two_frame_streaming", n_strm, 0);
    check("origin_empty_no_arm", 32'(fifo_rd_en), 32'd0);

    // Arming: FIFO fills mid-line 0, nothing pops until the next origin.
    run_to(260, 1'b1);
    clear_stats();
    run_to(383, 1'b0);
    check("arm_wait_pops", n_pop, 0);
    check("arm_wait_streaming", 32'(streaming), 32'd0);
    clear_stats();
    run_to(384, 1'b0);
    check("arm_rd_en", 32'(fifo_rd_en), 32'd1);
    check("arm_streaming_lag", 32'(streaming), 32'd0);
    run_to(385, 1'b0);
    check("arm_streaming", 32'(streaming), 32'd1);
    check("first_r", 32'(vga_r), 32'd31);
    check("first_g", 32'(vga_g), 32'd0);
    check("first_b", 32'(vga_b), 32'd0);
    check("first_fs", 32'(frame_start), 32'd1);
    run_to(399, 1'b0);
    check("line0_pops", n_pop, 8);
    run_to(511, 1'b0);
    check("frame_pops", n_pop, 32);
    check("blank_pops", n_blank_pop, 0);

    // Underflow: 5 empty active cycles on line 1.
    run_to(529, 1'b0);
    clear_stats();
    run_to(534, 1'b1);
    check("uf_cnt_4", 32'(underflow_cnt), 32'd4);
    run_to(535, 1'b0);
    check("uf_resume_rd_en", 32'(fifo_rd_en), 32'd1);
    check("uf_cnt_5", 32'(underflow_cnt), 32'd5);
    run_to(536, 1'b0);
    check("uf_black_de", n_black, 5);

    // Empty during horizontal blanking only.
    run_to(551, 1'b0);
    run_to(559, 1'b1);
    run_to(561, 1'b0);
    check("uf_blank_unchanged", 32'(underflow_cnt), 32'd5);

    // Saturation: preload 0xFFFE during vertical blanking, then 3 underflows.
    run_to(592, 1'b0);
    force dut.underflow_cnt_q = 16'hFFFE;
    run_to(593, 1'b0);
    release dut.underflow_cnt_q;
    check("sat_preload", 32'(underflow_cnt), 32'hFFFE);
    run_to(640, 1'b0);
    run_to(643, 1'b1);
    run_to(644, 1'b0);
    check("sat_ffff", 32'(underflow_cnt), 32'hFFFF);
    run_to(650, 1'b1);
    run_to(651, 1'b0);
    check("sat_hold", 32'(underflow_cnt), 32'hFFFF);

    // Reset in the middle of a sync-active blanking line.
    run_to(732, 1'b0);
    check("pre_rst_hsync", 32'(vga_hsync), 32'd0);
    check("pre_rst_vsync", 32'(vga_vsync), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hsync", 32'(vga_hsync), 32'd1);
    check("mid_rst_vsync", 32'(vga_vsync), 32'd1);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("mid_rst_ufcnt", 32'(underflow_cnt), 32'd0);
    check("mid_rst_streaming", 32'(streaming), 32'd0);
    prev_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2;
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    cyc = 0;
    #1;
    check("rel_fs_0", 32'(frame_start), 32'd0);
    run_to(1, 1'b1);
    check("rel_fs_1", 32'(frame_start), 32'd1);
    run_to(3, 1'b1);
    check("rel_fs_2", 32'(frame_start), 32'd0);
    check("rel_streaming", 32'(streaming), 32'd0);
    run_to(127, 1'b1);
    run_to(128, 1'b0);
    check("rearm_rd_en", 32'(fifo_rd_en), 32'd1);
    run_to(129, 1'b0);
    check("rearm_streaming", 32'(streaming), 32'd1);
    check("rearm_de", 32'(vga_de), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
